shift_unit_iter: RTL and testbench
==================================

// Module: shift_unit_iter
// PURPOSE
//  Multi-cycle, parametrised successor to the MCU's combinational shifter.
//  Executes LSL/LSR/ASR/ROR on DATA_W-bit operands, shifting at most STEP bits
//  per cycle, behind valid/ready handshakes on input and output.
//  Sits between the register-file read stage and writeback; shift_op encoding
//  is unchanged: [7:3] imm amount, [2:1] type, [0] amount source.
// PARAMETERS
//  DATA_W  32  operand/result width (power of 2, 8..64)
//  STEP    8   max bits shifted per SHIFT cycle (power of 2, 1..DATA_W)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       operand/op valid
//  in_ready   out  1       unit can accept an operand this cycle
//  shift_op   in   8       [7:3] imm amount, [2:1] 00 LSL/01 LSR/10 ASR/11 ROR, [0] 1 = use reg_amt
//  data_in    in   DATA_W  operand
//  reg_amt    in   8       register-sourced shift amount (all 8 bits used)
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  data_out   out  DATA_W  result (registered)
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, data_out=0, busy=0; in_ready=1 once rst_n high.
//  Reset asserted mid-operation aborts it immediately; the operand is discarded.
//  Raw amount A = shift_op[0] ? reg_amt : shift_op[7:3]; latched on accept.
//  Effective amount E: LSL/LSR/ASR: min(A, DATA_W); ROR: A mod DATA_W.
//  FSM IDLE -> SHIFT -> DONE:
//   IDLE: in_ready=1; on in_valid, latch operand/type/E; E==0 -> DONE, else SHIFT.
//   SHIFT: shift working reg by min(E_rem, STEP); E_rem -= that; when E_rem==0 -> DONE.
//   DONE: out_valid=1, data_out stable until out_ready; on out_ready -> IDLE,
//         or directly load next operand if in_valid (in_ready = out_ready in DONE).
//  Latency accept->out_valid = 1 + ceil(E/STEP) cycles; E==0 gives 1 cycle.
//  Fill: LSL/LSR zeros; ASR copies bit DATA_W-1; ROR wraps LSBs into MSBs.
//  A>=DATA_W: LSL/LSR -> 0; ASR -> all sign bits; completes within ceil(DATA_W/STEP) steps.
//  in_valid with in_ready low is ignored (no buffering); upstream must hold.
//  out_valid drops the cycle after an out_ready handshake unless a new op hit E==0.
// CONFIGURATION
//  SHIFT_CARRY_EN defined: adds ports carry_in (in,1) and carry_out (out,1).
//   carry_out = last bit shifted out (LSL: bit DATA_W-E; LSR/ASR: bit E-1; ROR: result
//   MSB); E==0 -> carry_out=carry_in latched on accept; A>DATA_W LSL/LSR -> 0,
//   ASR -> sign bit. Reset value 0, updated with data_out.
//  Undefined: ports absent, no carry logic; data behaviour identical.
// STRUCTURE
//  Package shift_pkg: shift type enum (SH_LSL/SH_LSR/SH_ASR/SH_ROR), FSM state
//  enum, shift_op field offsets, AMT_W=8.
//  Sub-module shift_step: combinational shift of working reg by 0..STEP bits
//  for a given type (and carry when SHIFT_CARRY_EN); instantiated once.
// TESTING
//  1 LSL imm 4, data 0x0000_00F1 -> 0x0000_0F10, out_valid 2 cycles after accept.
//  2 ASR reg_amt=40, data 0x8000_0000, STEP=8 -> 0xFFFF_FFFF after 5 cycles.
//  3 ROR reg_amt=36, data 0x1234_5678 -> E=4, 0x8123_4567; carry_out=1.
//  4 LSR imm 0, out_ready=0 for 5 cycles -> data_out held, in_ready=0, then
//    back-to-back accept on out_ready cycle with no bubble.
//  5 rst_n low mid-SHIFT (LSL 31) -> out_valid=0, data_out=0 asynchronously; next op clean.
//  6 Random op/amount/data sweep vs reference model, STEP in {1,8,32}, both macro states.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit.
//  - shift type encoding (matches the MCU's existing shift_op[2:1] field)
//  - FSM state encoding
//  - shift_op field offsets and register-amount width
package shift_pkg;

    localparam int AMT_W       = 8;   // width of register-sourced amount
    localparam int OP_SRC_BIT  = 0;   // 1 = amount from reg_amt
    localparam int OP_TYPE_LSB = 1;
    localparam int OP_TYPE_W   = 2;
    localparam int OP_AMT_LSB  = 3;
    localparam int OP_AMT_W    = 5;   // immediate amount field

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts data_in by amt (0..STEP) bits.
// Ports:
//  data_in   in   DATA_W  working value
//  amt       in   SW      bits to shift this step (0..STEP)
//  sh_type   in   2       LSL/LSR/ASR/ROR
//  carry_out out  1       last bit shifted out (only with SHIFT_CARRY_EN)
//  data_out  out  DATA_W  shifted value
// Optional feature macro: SHIFT_CARRY_EN.
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 8,
    localparam int SW    = $clog2(STEP) + 1
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [SW-1:0]     amt,
    input  shift_type_e       sh_type,
`ifdef SHIFT_CARRY_EN
    output logic              carry_out,
`endif
    output logic [DATA_W-1:0] data_out
);

    logic [2*DATA_W-1:0] rot_full;

    always_comb begin
        // Rotating the doubled word avoids a shift by DATA_W when amt is 0.
        rot_full = {data_in, data_in} >> amt;
        case (sh_type)
            SH_LSL:  data_out = data_in << amt;
            SH_LSR:  data_out = data_in >> amt;
            SH_ASR:  data_out = $signed(data_in) >>> amt;
            default: data_out = rot_full[DATA_W-1:0];
        endcase
    end

`ifdef SHIFT_CARRY_EN
    logic [DATA_W-1:0] lsb_side;
    logic [DATA_W-1:0] msb_side;

    // The last bit out is the one sitting one position short of the edge.
    // For ROR this is data_in[amt-1], which becomes the result MSB.
    always_comb begin
        lsb_side  = data_in >> (amt - SW'(1));
        msb_side  = data_in << (amt - SW'(1));
        carry_out = 1'b0;
        if (amt != '0) begin
            carry_out = (sh_type == SH_LSL) ? msb_side[DATA_W-1] : lsb_side[0];
        end
    end
`endif

endmodule

// File: rtl/shift_unit_iter.sv
// Iterative LSL/LSR/ASR/ROR unit: shifts at most STEP bits per cycle behind
// valid/ready handshakes. shift_op = {imm amount[4:0], type[1:0], src}.
// Ports:
//  clk, rst_n          clock (rising edge), asynchronous active-low reset
//  in_valid/in_ready   operand handshake (in_ready follows out_ready in DONE)
//  shift_op            [7:3] imm amount, [2:1] type, [0] 1 = use reg_amt
//  data_in, reg_amt    operand and register-sourced amount
//  out_valid/out_ready result handshake
//  data_out            registered result, stable while out_valid
//  busy                high whenever the FSM is not IDLE
//  carry_in/carry_out  only with SHIFT_CARRY_EN: last bit shifted out
// Optional feature macro: SHIFT_CARRY_EN.
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        shift_op,
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  reg_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
`ifdef SHIFT_CARRY_EN
    input  logic              carry_in,
    output logic              carry_out,
`endif
    output logic              busy
);

    localparam int EW = $clog2(DATA_W) + 1;   // holds 0..DATA_W
    localparam int SW = $clog2(STEP) + 1;     // holds 0..STEP

    state_e            state_reg, state_next;
    logic [DATA_W-1:0] work_reg;
    logic [DATA_W-1:0] result_reg;
    logic [EW-1:0]     e_rem_reg;
    shift_type_e       type_reg;

    logic [AMT_W-1:0]  raw_amt;
    shift_type_e       in_type;
    logic [EW-1:0]     eff_amt;
    logic [SW-1:0]     step_amt;
    logic [EW-1:0]     e_rem_after;
    logic [DATA_W-1:0] step_data;
    logic              accept;

    // Operand decode: raw amount, then clamp (LSL/LSR/ASR) or wrap (ROR).
    always_comb begin
        raw_amt = shift_op[OP_SRC_BIT] ? reg_amt
                                       : AMT_W'(shift_op[OP_AMT_LSB +: OP_AMT_W]);
        in_type = shift_type_e'(shift_op[OP_TYPE_LSB +: OP_TYPE_W]);
        if (in_type == SH_ROR) begin
            eff_amt = EW'(raw_amt & AMT_W'(DATA_W - 1));
        end else if (raw_amt >= AMT_W'(DATA_W)) begin
            eff_amt = EW'(DATA_W);
        end else begin
            eff_amt = EW'(raw_amt);
        end
    end

    // Per-cycle step: min(remaining, STEP).
    always_comb begin
        step_amt    = (e_rem_reg > EW'(STEP)) ? SW'(STEP) : SW'(e_rem_reg);
        e_rem_after = e_rem_reg - EW'(step_amt);
    end

`ifdef SHIFT_CARRY_EN
    logic step_carry;
    logic carry_reg;
    logic over_reg;      // raw amount strictly above DATA_W
    logic raw_over;

    assign raw_over = (raw_amt > AMT_W'(DATA_W));
`endif

    shift_step #(
        .DATA_W (DATA_W),
        .STEP   (STEP)
    ) u_step (
        .data_in   (work_reg),
        .amt       (step_amt),
        .sh_type   (type_reg),
`ifdef SHIFT_CARRY_EN
        .carry_out (step_carry),
`endif
        .data_out  (step_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = (eff_amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (e_rem_after == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // Result leaves and the next operand may enter in the same cycle.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept     = 1'b1;
                        state_next = (eff_amt == '0) ? ST_DONE : ST_SHIFT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg   <= '0;
            result_reg <= '0;
            e_rem_reg  <= '0;
            type_reg   <= SH_LSL;
`ifdef SHIFT_CARRY_EN
            carry_reg  <= 1'b0;
            over_reg   <= 1'b0;
`endif
        end else if (accept) begin
            work_reg  <= data_in;
            type_reg  <= in_type;
            e_rem_reg <= eff_amt;
`ifdef SHIFT_CARRY_EN
            over_reg  <= raw_over;
`endif
            if (eff_amt == '0) begin
                result_reg <= data_in;
`ifdef SHIFT_CARRY_EN
                carry_reg  <= carry_in;
`endif
            end
        end else if (state_reg == ST_SHIFT) begin
            work_reg  <= step_data;
            e_rem_reg <= e_rem_after;
            if (e_rem_after == '0) begin
                result_reg <= step_data;
`ifdef SHIFT_CARRY_EN
                // Amounts past the width shift out only zeros for LSL/LSR.
                // ASR already ends on the sign bit through normal stepping.
                if (over_reg && (type_reg == SH_LSL || type_reg == SH_LSR)) begin
                    carry_reg <= 1'b0;
                end else begin
                    carry_reg <= step_carry;
                end
`endif
            end
        end
    end

    assign data_out = result_reg;
    assign busy     = (state_reg != ST_IDLE);
`ifdef SHIFT_CARRY_EN
    assign carry_out = carry_reg;
`endif

endmodule

// File: tb/tb_shift_unit_iter.sv
// Bench for shift_unit_iter: three instances (STEP = 1, 8, 32) at DATA_W=32.
// Directed scenarios use the STEP=8 instance; the random sweep drives all
// three with the same operand and checks each against a reference model.
// Carry checks are active when SHIFT_CARRY_EN is defined.
module tb_shift_unit_iter;

    localparam int DW = 32;
    localparam int NI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NI-1:0]         iv   = '0;
    logic [NI-1:0]         ordy = '0;
    logic [NI-1:0]         ir, ov, bz;
    logic [NI-1:0][DW-1:0] dout;
    logic [7:0]            op   = '0;
    logic [DW-1:0]         din  = '0;
    logic [7:0]            ramt = '0;
    logic                  cin  = 1'b0;
`ifdef SHIFT_CARRY_EN
    logic [NI-1:0]         cout;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int step_of [NI] = '{1, 8, 32};

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 8 : 32);
            shift_unit_iter #(.DATA_W(DW), .STEP(ST)) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (iv[gi]),
                .in_ready  (ir[gi]),
                .shift_op  (op),
                .data_in   (din),
                .reg_amt   (ramt),
                .out_valid (ov[gi]),
                .out_ready (ordy[gi]),
                .data_out  (dout[gi]),
`ifdef SHIFT_CARRY_EN
                .carry_in  (cin),
                .carry_out (cout[gi]),
`endif
                .busy      (bz[gi])
            );
        end
    endgenerate

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: returns {carry, result} from the whole-amount rules.
    function automatic logic [DW:0] model(input logic [7:0] op_v, input logic [7:0] ra,
                                          input logic [DW-1:0] d, input logic ci);
        int a, t, e;
        logic [DW-1:0] r;
        logic c;
        a = op_v[0] ? int'(ra) : int'(op_v[7:3]);
        t = int'(op_v[2:1]);
        r = '0;
        c = ci;
        case (t)
            0: begin
                r = (a >= DW) ? '0 : (d << a);
                if (a > DW) c = 1'b0; else if (a > 0) c = d[DW - a];
            end
            1: begin
                r = (a >= DW) ? '0 : (d >> a);
                if (a > DW) c = 1'b0; else if (a > 0) c = d[a - 1];
            end
            2: begin
                r = (a >= DW) ? {DW{d[DW-1]}} : DW'($signed(d) >>> a);
                if (a >= DW) c = d[DW-1]; else if (a > 0) c = d[a - 1];
            end
            default: begin
                e = a % DW;
                r = (e == 0) ? d : ((d >> e) | (d << (DW - e)));
                if (e != 0) c = r[DW-1];
            end
        endcase
        return {c, r};
    endfunction

    function automatic int model_lat(input logic [7:0] op_v, input logic [7:0] ra, input int step);
        int a, e;
        a = op_v[0] ? int'(ra) : int'(op_v[7:3]);
        if (op_v[2:1] == 2'b11) e = a % DW;
        else e = (a > DW) ? DW : a;
        return 1 + (e + step - 1) / step;
    endfunction

    // Present the operand on the instances in mask for one accepting edge.
    task automatic issue(input logic [NI-1:0] mask);
        iv = mask;
        @(posedge clk); #1;
        iv = '0;
    endtask

    // Cycles from accept to out_valid for one instance; -1 on timeout.
    task automatic wait_valid(input int idx, output int lat);
        lat = 1;
        while (!ov[idx] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov[idx]) lat = -1;
    endtask

    task automatic pop(input logic [NI-1:0] mask);
        ordy = mask;
        @(posedge clk); #1;
        ordy = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (ov[i] !== 1'b0 || dout[i] !== '0 || bz[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset[%0d]: out_valid=%b data_out=%h busy=%b, want 0/0/0", i, ov[i], dout[i], bz[i]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ir !== 3'b111) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 111", ir);
        end
        $display("reset: out_valid=%b busy=%b in_ready=%b", ov, bz, ir);
    endtask

    task automatic test_lsl_imm;
        int lat;
        op = {5'd4, 2'b00, 1'b0}; din = 32'h0000_00F1; cin = 1'b1;
        issue(3'b010);
        n_cmp++;
        if (bz[1] !== 1'b1) begin
            n_err++;
            $display("FAIL lsl_busy: got %b want 1", bz[1]);
        end
        wait_valid(1, lat);
        n_cmp++;
        if (lat != 2) begin n_err++; $display("FAIL lsl_latency: got %0d want 2", lat); end
        n_cmp++;
        if (dout[1] !== 32'h0000_0F10) begin n_err++; $display("FAIL lsl_data: got %h want 00000f10", dout[1]); end
`ifdef SHIFT_CARRY_EN
        n_cmp++;
        if (cout[1] !== 1'b0) begin n_err++; $display("FAIL lsl_carry: got %b want 0", cout[1]); end
`endif
        pop(3'b010);
        n_cmp++;
        if (ov[1] !== 1'b0 || bz[1] !== 1'b0) begin
            n_err++;
            $display("FAIL lsl_drain: out_valid=%b busy=%b want 0/0", ov[1], bz[1]);
        end
        $display("lsl imm4: data=%h lat=%0d", dout[1], lat);
    endtask

    task automatic test_asr_reg;
        int lat;
        op = {5'd0, 2'b10, 1'b1}; ramt = 8'd40; din = 32'h8000_0000;
        issue(3'b010);
        wait_valid(1, lat);
        n_cmp++;
        if (lat != 5) begin n_err++; $display("FAIL asr_latency: got %0d want 5", lat); end
        n_cmp++;
        if (dout[1] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL asr_data: got %h want ffffffff", dout[1]); end
`ifdef SHIFT_CARRY_EN
        n_cmp++;
        if (cout[1] !== 1'b1) begin n_err++; $display("FAIL asr_carry: got %b want 1", cout[1]); end
`endif
        pop(3'b010);
        $display("asr reg40: data=%h lat=%0d", dout[1], lat);
    endtask

    task automatic test_ror_reg;
        int lat;
        op = {5'd0, 2'b11, 1'b1}; ramt = 8'd36; din = 32'h1234_5678;
        issue(3'b010);
        wait_valid(1, lat);
        n_cmp++;
        if (lat != 2) begin n_err++; $display("FAIL ror_latency: got %0d want 2", lat); end
        n_cmp++;
        if (dout[1] !== 32'h8123_4567) begin n_err++; $display("FAIL ror_data: got %h want 81234567", dout[1]); end
`ifdef SHIFT_CARRY_EN
        n_cmp++;
        if (cout[1] !== 1'b1) begin n_err++; $display("FAIL ror_carry: got %b want 1", cout[1]); end
`endif
        pop(3'b010);
        $display("ror reg36: data=%h lat=%0d", dout[1], lat);
    endtask

    task automatic test_back_to_back;
        int lat;
        op = {5'd0, 2'b01, 1'b0}; din = 32'hA5A5_0F0F; cin = 1'b1;
        issue(3'b010);
        wait_valid(1, lat);
        n_cmp++;
        if (lat != 1) begin n_err++; $display("FAIL b2b_latency: got %0d want 1", lat); end
        din = 32'h0;   // operand bus changes; held result must not follow it
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (ov[1] !== 1'b1 || dout[1] !== 32'hA5A5_0F0F || ir[1] !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_hold[%0d]: out_valid=%b data=%h in_ready=%b want 1/a5a50f0f/0", c, ov[1], dout[1], ir[1]);
            end
            @(posedge clk); #1;
        end
`ifdef SHIFT_CARRY_EN
        n_cmp++;
        if (cout[1] !== 1'b1) begin n_err++; $display("FAIL b2b_carry: got %b want 1", cout[1]); end
`endif
        op = {5'd0, 2'b00, 1'b0}; din = 32'h1357_9BDF; cin = 1'b0;
        ordy = 3'b010; iv = 3'b010;
        #1;
        n_cmp++;
        if (ir[1] !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b want 1", ir[1]); end
        @(posedge clk); #1;
        iv = '0; ordy = '0;
        n_cmp++;
        if (ov[1] !== 1'b1 || dout[1] !== 32'h1357_9BDF) begin
            n_err++;
            $display("FAIL b2b_next: out_valid=%b data=%h want 1/13579bdf", ov[1], dout[1]);
        end
`ifdef SHIFT_CARRY_EN
        n_cmp++;
        if (cout[1] !== 1'b0) begin n_err++; $display("FAIL b2b_next_carry: got %b want 0", cout[1]); end
`endif
        pop(3'b010);
        n_cmp++;
        if (ov[1] !== 1'b0) begin n_err++; $display("FAIL b2b_drain: out_valid=%b want 0", ov[1]); end
        $display("back_to_back: data=%h", dout[1]);
    endtask

    task automatic test_reset_mid;
        int lat;
        op = {5'd31, 2'b00, 1'b0}; din = 32'hFFFF_FFFF;
        issue(3'b010);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ov[1] !== 1'b0 || dout[1] !== '0 || bz[1] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: out_valid=%b data=%h busy=%b want 0/0/0", ov[1], dout[1], bz[1]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ir[1] !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b want 1", ir[1]); end
        @(posedge clk); #1;
        op = {5'd1, 2'b00, 1'b0}; din = 32'h8000_0001;
        issue(3'b010);
        wait_valid(1, lat);
        n_cmp++;
        if (lat != 2 || dout[1] !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL rst_mid_next: lat=%0d data=%h want 2/00000002", lat, dout[1]);
        end
`ifdef SHIFT_CARRY_EN
        n_cmp++;
        if (cout[1] !== 1'b1) begin n_err++; $display("FAIL rst_mid_carry: got %b want 1", cout[1]); end
`endif
        pop(3'b010);
        $display("reset_mid: next data=%h lat=%0d", dout[1], lat);
    endtask

    task automatic test_random;
        int lat [NI];
        int exp_lat;
        int c;
        logic [DW:0] exp;
        for (int n = 0; n < 60; n++) begin
            op  = 8'($urandom);
            din = $urandom;
            cin = 1'($urandom);
            case ($urandom_range(0, 5))
                0: ramt = 8'd0;
                1: ramt = 8'd32;
                2: ramt = 8'd33;
                3: ramt = 8'd255;
                4: ramt = 8'd31;
                default: ramt = 8'($urandom);
            endcase
            exp = model(op, ramt, din, cin);
            issue(3'b111);
            for (int i = 0; i < NI; i++) lat[i] = 0;
            c = 1;
            while (c < 100) begin
                for (int i = 0; i < NI; i++) if (ov[i] && lat[i] == 0) lat[i] = c;
                if (ov == 3'b111) break;
                @(posedge clk); #1;
                c++;
            end
            for (int i = 0; i < NI; i++) begin
                exp_lat = model_lat(op, ramt, step_of[i]);
                n_cmp++;
                if (dout[i] !== exp[DW-1:0] || lat[i] != exp_lat) begin
                    n_err++;
                    $display("FAIL rand[%0d] step%0d op=%h amt=%0d din=%h: data=%h lat=%0d want %h/%0d",
                             n, step_of[i], op, ramt, din, dout[i], lat[i], exp[DW-1:0], exp_lat);
                end
`ifdef SHIFT_CARRY_EN
                n_cmp++;
                if (cout[i] !== exp[DW]) begin
                    n_err++;
                    $display("FAIL rand_carry[%0d] step%0d op=%h amt=%0d: got %b want %b",
                             n, step_of[i], op, ramt, cout[i], exp[DW]);
                end
`endif
            end
            pop(3'b111);
            n_cmp++;
            if (ov !== 3'b000) begin n_err++; $display("FAIL rand_drain[%0d]: out_valid=%b want 000", n, ov); end
            $display("rand %0d: op=%h amt=%0d din=%h -> %h lat=%0d/%0d/%0d",
                     n, op, ramt, din, exp[DW-1:0], lat[0], lat[1], lat[2]);
        end
    endtask

    initial begin
        test_reset();
        test_lsl_imm();
        test_asr_reg();
        test_ror_reg();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
